// File: rtl/sort_n_seq.sv
// sort_n_seq: collects N {signed value, index} records, sorts them in place
// with an N-phase odd-even transposition network (one phase per clock),
// then streams the sorted records out in ascending or descending order.
module sort_n_seq #(
  parameter int N     = 4,
  parameter int VAL_W = 6,
  parameter int IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VAL_W+IDX_W-1:0] in_data,
  input  logic                   descend,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VAL_W+IDX_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int REC_W = VAL_W + IDX_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, phase;
  logic             desc;
  logic [REC_W-1:0] rec_buf [N];
  logic [REC_W-1:0] sorted  [N];

  // One transposition phase: even phases pair (0,1),(2,3)..., odd phases
  // pair (1,2),(3,4)...; swap only on strict disorder so ties stay stable.
  always_comb begin
    sorted = rec_buf;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (i[0] == phase[0]) begin
        if (desc ? ($signed(rec_buf[CNT_W'(i)][REC_W-1:IDX_W]) <
                    $signed(rec_buf[CNT_W'(i+1)][REC_W-1:IDX_W]))
                 : ($signed(rec_buf[CNT_W'(i)][REC_W-1:IDX_W]) >
                    $signed(rec_buf[CNT_W'(i+1)][REC_W-1:IDX_W]))) begin
          sorted[CNT_W'(i)]   = rec_buf[CNT_W'(i+1)];
          sorted[CNT_W'(i+1)] = rec_buf[CNT_W'(i)];
        end
      end
    end
  end

  // Next-state and handshake/output decode; outputs are pure functions of
  // state so reset drives them to their idle values asynchronously.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_cnt == LAST) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (phase == LAST) state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = rec_buf[rd_cnt];
        out_last  = (rd_cnt == LAST);
        if (out_ready && rd_cnt == LAST) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State register, counters, order latch and record buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      wr_cnt <= '0;
      rd_cnt <= '0;
      phase  <= '0;
      desc   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) rec_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          if (in_valid) begin
            rec_buf[wr_cnt] <= in_data;
            if (wr_cnt == '0) desc <= descend;
            wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
            phase  <= '0;
          end
        end
        SORT: begin
          rec_buf <= sorted;
          if (phase == LAST) begin
            phase  <= '0;
            rd_cnt <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_n_seq.sv
// Directed bench for sort_n_seq: an N=4/VAL_W=6 instance and an
// N=8/VAL_W=8 instance, with hand-computed expected output sequences.
module tb_sort_n_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // N=4 instance
  logic        a_in_valid, a_in_ready, a_descend, a_out_valid, a_out_ready;
  logic        a_out_last, a_busy;
  logic [10:0] a_in_data, a_out_data;
  // N=8 instance
  logic        b_in_valid, b_in_ready, b_descend, b_out_valid, b_out_ready;
  logic        b_out_last, b_busy;
  logic [12:0] b_in_data, b_out_data;

  sort_n_seq #(.N(4), .VAL_W(6), .IDX_W(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .descend(a_descend), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .busy(a_busy));

  sort_n_seq #(.N(8), .VAL_W(8), .IDX_W(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .descend(b_descend), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .busy(b_busy));

  int av[4], ai[4], eav[4], eai[4];
  int bv[8], bi[8], ebv[8], ebi[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] rec_a(input int v, input int ix);
    logic [31:0] vv, ii;
    vv = v; ii = ix;
    return {vv[5:0], ii[4:0]};
  endfunction

  function automatic logic [12:0] rec_b(input int v, input int ix);
    logic [31:0] vv, ii;
    vv = v; ii = ix;
    return {vv[7:0], ii[4:0]};
  endfunction

  // Present the four records of av/ai; descend is inverted after the first
  // handshake to show only the first one is latched.
  task automatic load_a(input logic d, input logic hold_valid);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("a_in_ready_load", a_in_ready, 1);
      a_in_valid = 1'b1;
      a_in_data  = rec_a(av[k], ai[k]);
      a_descend  = (k == 0) ? d : ~d;
      @(posedge clk);
      #1;
      a_in_valid = hold_valid;
      a_descend  = 1'b0;
    end
  endtask

  // out_valid must stay low for exactly four negedges after the last accept.
  task automatic latency_a();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("a_latency_low", a_out_valid, 0);
      chk("a_sort_busy", a_busy, 1);
      chk("a_sort_in_ready", a_in_ready, 0);
    end
    @(negedge clk);
    chk("a_latency_high", a_out_valid, 1);
  endtask

  task automatic drain_a(input int stalls);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < stalls; s++) begin
        a_out_ready = 1'b0;
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_data", a_out_data, rec_a(eav[k], eai[k]));
        chk("a_hold_last", a_out_last, (k == 3));
        chk("a_out_in_ready", a_in_ready, 0);
        @(negedge clk);
      end
      if (k == 3) a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      chk("a_out_valid", a_out_valid, 1);
      chk("a_out_data", a_out_data, rec_a(eav[k], eai[k]));
      chk("a_out_last", a_out_last, (k == 3));
      chk("a_out_in_ready", a_in_ready, 0);
      @(negedge clk);
    end
    chk("a_done_in_ready", a_in_ready, 1);
    chk("a_done_valid", a_out_valid, 0);
    chk("a_done_busy", a_busy, 0);
  endtask

  task automatic load_b(input logic d);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_in_ready_load", b_in_ready, 1);
      b_in_valid = 1'b1;
      b_in_data  = rec_b(bv[k], bi[k]);
      b_descend  = (k == 0) ? d : ~d;
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_descend  = 1'b0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("b_latency_low", b_out_valid, 0);
    end
    @(negedge clk);
    chk("b_latency_high", b_out_valid, 1);
  endtask

  task automatic drain_b();
    for (int k = 0; k < 8; k++) begin
      b_out_ready = 1'b1;
      chk("b_out_valid", b_out_valid, 1);
      chk("b_out_data", b_out_data, rec_b(ebv[k], ebi[k]));
      chk("b_out_last", b_out_last, (k == 7));
      @(negedge clk);
    end
    chk("b_done_in_ready", b_in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_descend = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_descend = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_data", a_out_data, 0);
    rst = 1'b0;

    // 1: descending
    av = '{4, -2, -32, -11}; ai = '{1, 2, 3, 4};
    eav = '{4, -2, -11, -32}; eai = '{1, 2, 4, 3};
    load_a(1'b1, 1'b0); latency_a(); drain_a(0);

    // 2: same inputs, ascending
    eav = '{-32, -11, -2, 4}; eai = '{3, 4, 2, 1};
    load_a(1'b0, 1'b0); latency_a(); drain_a(0);

    // 3: ties keep arrival order
    av = '{3, 3, -1, 3}; ai = '{1, 2, 3, 4};
    eav = '{-1, 3, 3, 3}; eai = '{3, 1, 2, 4};
    load_a(1'b0, 1'b0); latency_a(); drain_a(0);

    // 4: backpressure with in_valid held high through SORT/OUT
    av = '{4, -2, -32, -11}; ai = '{1, 2, 3, 4};
    eav = '{4, -2, -11, -32}; eai = '{1, 2, 4, 3};
    load_a(1'b1, 1'b1); latency_a(); drain_a(1);

    // 5: reset in the second SORT cycle, then a fresh batch
    load_a(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("a_mid_sort_busy", a_busy, 1);
    rst = 1'b1;
    #1;
    chk("a_async_in_ready", a_in_ready, 1);
    chk("a_async_busy", a_busy, 0);
    chk("a_async_valid", a_out_valid, 0);
    chk("a_async_last", a_out_last, 0);
    chk("a_async_data", a_out_data, 0);
    #2;
    rst = 1'b0;
    av = '{5, 1, 0, -5}; ai = '{0, 1, 2, 3};
    eav = '{5, 1, 0, -5}; eai = '{0, 1, 2, 3};
    load_a(1'b1, 1'b0); latency_a(); drain_a(0);

    // 6: N=8, two back-to-back batches with different order
    bv = '{7, 6, 5, 4, 3, 2, 1, 0}; bi = '{0, 1, 2, 3, 4, 5, 6, 7};
    ebv = '{0, 1, 2, 3, 4, 5, 6, 7}; ebi = '{7, 6, 5, 4, 3, 2, 1, 0};
    load_b(1'b0); drain_b();
    bv = '{-128, 127, 0, -1, 5, -5, 64, -64}; bi = '{0, 1, 2, 3, 4, 5, 6, 7};
    ebv = '{127, 64, 5, 0, -1, -5, -64, -128}; ebi = '{1, 6, 4, 2, 3, 5, 7, 0};
    load_b(1'b1); drain_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
